// File: rtl/uart_tx.sv
// UART transmitter: a bus write pushes one byte into a circular FIFO and an
// 8N1 state machine drains it, one bit per DIV clock cycles.
module uart_tx #(
  parameter int unsigned CLOCK_RATE = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DEPTH      = 16
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_waiting,
  output logic        o_empty,
  output logic        UART_TX
);

  localparam int unsigned DIV = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(DIV - 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
  localparam logic [NW-1:0] COUNT_FULL = NW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic          accepted_q;
  logic          push, pop, last_tick;
  logic [23:0]   unused_wdata;

  assign unused_wdata = i_wdata[31:8];

  // Handshake: valid = i_enable, ready = o_ready. One push per enable
  // assertion; accepted_q stays set until the edge that sees i_enable low.
  // Fullness is judged on the registered count, so a same-edge pop never
  // frees space for a push.
  assign push      = i_reset_n && i_enable && !accepted_q && (count != COUNT_FULL);
  assign o_ready   = accepted_q;
  assign o_waiting = i_enable && !accepted_q && (count == COUNT_FULL);
  assign o_empty   = (state_q == IDLE) && (count == '0);
  assign last_tick = (baud_q == BAUD_LAST);

  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr] <= i_wdata[7:0];
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      accepted_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
      if (push)           accepted_q <= 1'b1;
      else if (!i_enable) accepted_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    UART_TX = 1'b1;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        UART_TX = 1'b0;
        if (last_tick) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        UART_TX = shift_q[0];
        if (last_tick) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (last_tick) begin
          baud_d = '0;
          // Back-to-back frames: reload straight into START with no idle gap.
          if (count != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=10, DEPTH=16: records the serial line once
// per cycle and compares it against an expected bit stream built per scenario.
module tb_uart_tx;

  localparam int DIV = 10;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] wdata;
  logic        o_ready, o_waiting, o_empty, uart_line;

  int checks   = 0;
  int failures = 0;

  logic       rec = 1'b0;
  logic       tx_q[$];
  logic       rdy_q[$];
  logic       wt_q[$];
  logic [0:0] exp_q[$];

  uart_tx #(.CLOCK_RATE(1000), .BAUD_RATE(100), .DEPTH(16)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_enable  (en),
    .i_wdata   (wdata),
    .o_ready   (o_ready),
    .o_waiting (o_waiting),
    .o_empty   (o_empty),
    .UART_TX   (uart_line)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // one sample per cycle, 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    if (rec) begin
      tx_q.push_back(uart_line);
      rdy_q.push_back(o_ready);
      wt_q.push_back(o_waiting);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    tx_q.delete();
    rdy_q.delete();
    wt_q.delete();
    exp_q.delete();
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  task automatic add_frame(input logic [7:0] b);
    repeat (DIV) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (DIV) exp_q.push_back(b[i]);
    repeat (DIV) exp_q.push_back(1'b1);
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (tx_q.size() < n && k < n + 500) begin
      @(negedge clk);
      k++;
    end
    check("log_length", (tx_q.size() >= n), 1);
  endtask

  task automatic compare_log(input string tag, input int n);
    for (int i = 0; i < n && i < tx_q.size(); i++)
      check($sformatf("%s_tx[%0d]", tag, i), tx_q[i], exp_q[i]);
  endtask

  // driver: caller is at a falling edge; returns one falling edge after en drops
  task automatic write(input logic [31:0] d);
    int n;
    en = 1'b1;
    wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ready && n < 300);
    check("write_ack", o_ready, 1);
    en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] b3 [18];
    int         k;

    rst_n = 1'b0;
    en    = 1'b0;
    wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", uart_line, 1);
    check("rst_ready", o_ready, 0);
    check("rst_waiting", o_waiting, 0);
    check("rst_empty", o_empty, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single byte 0x55, latency and idle afterwards
    clear_log();
    rec = 1'b1;
    write(32'h0000_0055);
    check("t1_busy_empty", o_empty, 0);
    add_idle(1);
    add_frame(8'h55);
    add_idle(20);
    wait_log(exp_q.size());
    compare_log("t1", exp_q.size());
    check("t1_end_empty", o_empty, 1);
    rec = 1'b0;

    // three back-to-back bytes, contiguous frames
    @(negedge clk);
    clear_log();
    rec = 1'b1;
    write(32'h0000_0001);
    write(32'h0000_0080);
    write(32'h0000_00FF);
    add_idle(1);
    add_frame(8'h01);
    add_frame(8'h80);
    add_frame(8'hFF);
    add_idle(20);
    wait_log(exp_q.size());
    compare_log("t2", exp_q.size());
    rec = 1'b0;

    // 18 writes: FIFO fills, 18th stalls until the first pop after frame 1
    for (int i = 0; i < 18; i++) b3[i] = 8'(i * 29 + 7);
    @(negedge clk);
    clear_log();
    rec = 1'b1;
    for (int i = 0; i < 18; i++) write({24'hABCDEF, b3[i]});
    add_idle(1);
    for (int i = 0; i < 18; i++) add_frame(b3[i]);
    add_idle(20);
    wait_log(exp_q.size());
    compare_log("t3", exp_q.size());
    for (int i = 34; i <= 100; i++) begin
      check($sformatf("t3_waiting[%0d]", i), wt_q[i], 1);
      check($sformatf("t3_ready[%0d]", i), rdy_q[i], 0);
    end
    check("t3_waiting_101", wt_q[101], 0);
    check("t3_ready_101", rdy_q[101], 0);
    check("t3_ready_102", rdy_q[102], 1);
    check("t3_waiting_102", wt_q[102], 0);
    rec = 1'b0;

    // enable held 50 cycles, upper data bits ignored, data changed after accept
    @(negedge clk);
    clear_log();
    rec = 1'b1;
    en = 1'b1;
    wdata = 32'hFFFF_FF41;
    @(negedge clk);
    check("t4_ready_first", o_ready, 1);
    wdata = 32'h0000_00AA;
    for (int i = 2; i <= 50; i++) begin
      @(negedge clk);
      check($sformatf("t4_ready_held[%0d]", i), o_ready, 1);
      check($sformatf("t4_waiting_held[%0d]", i), o_waiting, 0);
    end
    en = 1'b0;
    @(negedge clk);
    check("t4_ready_drop", o_ready, 0);
    add_idle(1);
    add_frame(8'h41);
    add_idle(100);
    wait_log(exp_q.size());
    compare_log("t4", exp_q.size());
    rec = 1'b0;

    // reset 35 cycles into a frame with three bytes queued
    @(negedge clk);
    clear_log();
    rec = 1'b1;
    write(32'h0000_00A5);
    write(32'h0000_0012);
    write(32'h0000_0034);
    write(32'h0000_0056);
    k = 0;
    while (tx_q.size() < 36 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t5_reached_35", tx_q.size(), 36);
    add_idle(1);
    add_frame(8'hA5);
    compare_log("t5_pre", 36);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_tx", uart_line, 1);
    check("t5_rst_empty", o_empty, 1);
    check("t5_rst_ready", o_ready, 0);
    check("t5_rst_waiting", o_waiting, 0);
    rst_n = 1'b1;
    clear_log();
    add_idle(300);
    wait_log(exp_q.size());
    compare_log("t5_post", exp_q.size());
    check("t5_post_empty", o_empty, 1);
    rec = 1'b0;

    // write held across reset deassertion is accepted exactly once
    @(negedge clk);
    clear_log();
    rst_n = 1'b0;
    en = 1'b1;
    wdata = 32'h1234_563C;
    rec = 1'b1;
    @(negedge clk);
    check("t6_ready_in_reset", o_ready, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b0;
    add_idle(2);
    add_frame(8'h3C);
    add_idle(60);
    wait_log(exp_q.size());
    compare_log("t6", exp_q.size());
    check("t6_ready_idx0", rdy_q[0], 0);
    check("t6_ready_idx1", rdy_q[1], 1);
    rec = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate in bits/s.
REQ-003 SHALL have parameter DEPTH, default 16, meaning transmit FIFO capacity in bytes.
REQ-004 i_clock  input  1  sole clock; all logic on rising edge.
REQ-005 i_reset_n  input  1  reset; one clock, synchronous, active-low.
REQ-006 i_enable  input  1  bus write request; held high until o_ready is seen.
REQ-007 i_wdata  input  32  write data; only [7:0] is used, [31:8] is ignored.
REQ-008 o_ready  output  1  write accepted; held high while i_enable remains high.
REQ-009 o_waiting  output  1  write stalled because the FIFO is full.
REQ-010 o_empty  output  1  FIFO empty and line idle (no frame in progress).
REQ-011 UART_TX  output  1  serial line, idle high.

Function
REQ-012 SHALL derive bit period DIV = CLOCK_RATE/BAUD_RATE, integer-truncated, from an internal counter on i_clock; no derived clocks.
REQ-013 SHALL send 8N1 frames: start bit 0, data bits LSB first, one stop bit 1; each bit lasts exactly DIV cycles; frame = 10*DIV cycles.
REQ-014 Write handshake: on an edge with i_enable=1, rd-side FIFO count < DEPTH and no push yet in this enable assertion, push i_wdata[7:0]; o_ready=1 from that edge until the edge after i_enable falls.
REQ-015 Exactly one byte SHALL be pushed per i_enable assertion, regardless of how long i_enable is held.
REQ-016 If i_enable=1 and the FIFO is full, SHALL not push; o_waiting=1, o_ready=0 until space exists, then push on the first edge with space.
REQ-017 A push SHALL be refused on an edge where the FIFO is full, even if a pop occurs on the same edge; accepted one edge later.
REQ-018 o_waiting SHALL be 0 whenever i_enable=0 or the write has been accepted.
REQ-019 State machine states: IDLE, START, DATA, STOP.
REQ-020 IDLE: UART_TX=1; if FIFO non-empty, pop byte into shift register, reset bit counter, go to START.
REQ-021 START: UART_TX=0 for DIV cycles, then DATA.
REQ-022 DATA: UART_TX = shift register LSB; shift every DIV cycles; after 8 bits go to STOP.
REQ-023 STOP: UART_TX=1 for DIV cycles; on last cycle, if FIFO non-empty pop and go directly to START (no idle gap), else IDLE.
REQ-024 Latency: byte accepted at edge E into an empty, idle block SHALL drive UART_TX=0 after edge E+1.
REQ-025 FIFO SHALL be circular with wrapping read/write pointers and a count 0..DEPTH; simultaneous push and pop leave count unchanged.
REQ-026 o_empty SHALL be 1 only in IDLE with FIFO count 0.
REQ-027 i_wdata SHALL be sampled only on the accepting edge; later changes do not affect the queued byte.

Reset
REQ-028 While i_reset_n=0 at a rising edge: state=IDLE, FIFO count and pointers=0, UART_TX=1, o_ready=0, o_waiting=0, o_empty=1, baud and bit counters=0.
REQ-029 Reset mid-frame SHALL abort the frame: UART_TX=1 after that edge; queued bytes are discarded and never transmitted.
REQ-030 A write held across reset deassertion SHALL be treated as a new assertion and accepted once.

Verification (CLOCK_RATE=1000, BAUD_RATE=100, DIV=10, DEPTH=16)
REQ-031 Reset, write 0x55 -> UART_TX low after E+1; bits 1,0,1,0,1,0,1,0 of 10 cycles each; stop high 10 cycles; o_empty=1 after 100 cycles.
REQ-032 Three writes 0x01,0x80,0xFF back-to-back -> 300 contiguous frame cycles, no idle between stop and next start, correct bit patterns.
REQ-033 17 writes while first frame runs -> writes 2..17 accepted (16 in FIFO); 18th holds o_waiting=1, o_ready=0 until first pop after frame 1 end, then accepted; all 18 bytes sent in order.
REQ-034 i_enable held 50 cycles with i_wdata=0xFFFFFF41 -> o_ready high from accept until i_enable falls; exactly one frame carrying 0x41.
REQ-035 Reset asserted 35 cycles into a frame with 3 bytes queued -> UART_TX=1 next edge, o_empty=1, no further frames without new writes.
